// File: rtl/uart_tx_arbiter.sv
// Three-requester round-robin arbiter feeding one 8N1 UART serializer.
// A granted requester owns the line until its last byte, or until it idles for HOLD_TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int HOLD_TIMEOUT = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_req,
    input  logic [7:0] i_data0,
    input  logic [7:0] i_data1,
    input  logic [7:0] i_data2,
    input  logic [2:0] i_last,
    output logic [2:0] o_ack,
    output logic       o_line_tx,
    output logic       o_busy,
    output logic [1:0] o_grant,
    output logic       o_locked
);

    localparam int BIT_CNT = CLK_FREQ / BAUD;
    localparam int BCW     = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
    localparam int TOW     = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(BIT_CNT - 1);
    localparam logic [TOW-1:0] HOLD_LAST = TOW'(HOLD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [7:0]     r_shift;
    logic [2:0]     r_bit_idx;
    logic [BCW-1:0] r_baud;
    logic [TOW-1:0] r_hold;
    logic           r_last_q;
    logic [1:0]     r_grant;
    logic           r_locked;
    logic [1:0]     r_rr_ptr;
    logic [2:0]     r_ack;

    logic           w_bit_done;
    logic           w_accept;
    logic           w_owner_req;
    logic           w_hold_expire;
    logic [1:0]     w_sel;
    logic [1:0]     w_p1;
    logic [1:0]     w_p2;
    logic [7:0]     w_sel_data;
    logic           w_sel_last;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic req_of(input logic [2:0] req, input logic [1:0] idx);
        logic sel;
        sel = 1'b0;
        case (idx)
            2'd0:    sel = req[0];
            2'd1:    sel = req[1];
            2'd2:    sel = req[2];
            default: sel = 1'b0;
        endcase
        return sel;
    endfunction

    assign w_bit_done    = (r_baud == BIT_LAST);
    assign w_owner_req   = req_of(i_req, r_grant);
    assign w_hold_expire = (r_state == S_IDLE) && r_locked && !w_owner_req && (r_hold == HOLD_LAST);
    assign w_p1          = next_idx(r_rr_ptr);
    assign w_p2          = next_idx(w_p1);

    // While locked only the owner may send; otherwise search from the round-robin pointer.
    always_comb begin
        w_accept = 1'b0;
        w_sel    = r_rr_ptr;
        if (r_state == S_IDLE) begin
            if (r_locked) begin
                w_accept = w_owner_req;
                w_sel    = r_grant;
            end else if (req_of(i_req, r_rr_ptr)) begin
                w_accept = 1'b1;
                w_sel    = r_rr_ptr;
            end else if (req_of(i_req, w_p1)) begin
                w_accept = 1'b1;
                w_sel    = w_p1;
            end else if (req_of(i_req, w_p2)) begin
                w_accept = 1'b1;
                w_sel    = w_p2;
            end
        end
    end

    always_comb begin
        w_sel_data = i_data2;
        w_sel_last = i_last[2];
        case (w_sel)
            2'd0: begin
                w_sel_data = i_data0;
                w_sel_last = i_last[0];
            end
            2'd1: begin
                w_sel_data = i_data1;
                w_sel_last = i_last[1];
            end
            default: begin
                w_sel_data = i_data2;
                w_sel_last = i_last[2];
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_START;
            S_START: if (w_bit_done) w_state_next = S_DATA;
            S_DATA:  if (w_bit_done && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
            S_STOP:  if (w_bit_done) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: acceptance latch, baud/bit counters, lock release and hold timeout.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_baud    <= '0;
            r_hold    <= '0;
            r_last_q  <= 1'b0;
            r_grant   <= '0;
            r_locked  <= 1'b0;
            r_rr_ptr  <= '0;
            r_ack     <= '0;
        end else begin
            r_ack <= 3'b000;
            if ((r_state == S_IDLE) || w_bit_done) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ack     <= 3'b001 << w_sel;
                        r_shift   <= w_sel_data;
                        r_last_q  <= w_sel_last;
                        r_grant   <= w_sel;
                        r_locked  <= 1'b1;
                        r_bit_idx <= '0;
                        r_hold    <= '0;
                    end else if (w_hold_expire) begin
                        r_locked <= 1'b0;
                        r_rr_ptr <= next_idx(r_grant);
                        r_hold   <= '0;
                    end else if (r_locked && !w_owner_req) begin
                        r_hold <= r_hold + 1'b1;
                    end else begin
                        r_hold <= '0;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_done && r_last_q) begin
                        r_locked <= 1'b0;
                        r_rr_ptr <= next_idx(r_grant);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_line_tx = 1'b1;
        case (r_state)
            S_START: o_line_tx = 1'b0;
            S_DATA:  o_line_tx = r_shift[0];
            default: o_line_tx = 1'b1;
        endcase
        o_busy   = (r_state != S_IDLE);
        o_ack    = r_ack;
        o_grant  = r_grant;
        o_locked = r_locked;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random round-robin rounds,
// checked against a message-level arbitration model and an ideal 8N1 frame waveform.
module tb_uart_tx_arbiter;

    localparam int CLK_FREQ_TB = 800;
    localparam int BAUD_TB     = 100;
    localparam int HOLD_TB     = 100;
    localparam int BC          = CLK_FREQ_TB / BAUD_TB;
    localparam int FRAME       = 10 * BC;

    logic       clk = 1'b0;
    logic       rstN;
    logic [2:0] req;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [2:0] last;
    logic [2:0] ack;
    logic       lineTx;
    logic       busy;
    logic [1:0] grant;
    logic       locked;

    int checks   = 0;
    int failures = 0;
    int rrPtr    = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .CLK_FREQ    (CLK_FREQ_TB),
        .BAUD        (BAUD_TB),
        .HOLD_TIMEOUT(HOLD_TB)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rstN),
        .i_req    (req),
        .i_data0  (data0),
        .i_data1  (data1),
        .i_data2  (data2),
        .i_last   (last),
        .o_ack    (ack),
        .o_line_tx(lineTx),
        .o_busy   (busy),
        .o_grant  (grant),
        .o_locked (locked)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [7:0] d2, input logic [2:0] l);
        req   = r;
        data0 = d0;
        data1 = d1;
        data2 = d2;
        last  = l;
    endtask

    // Round-robin choice: first requester at or after the pointer, wrapping modulo 3.
    function automatic int pickRr(input logic [2:0] r, input int ptr);
        for (int k = 0; k < 3; k++) begin
            if (r[(ptr + k) % 3]) return (ptr + k) % 3;
        end
        return -1;
    endfunction

    task automatic waitAck(output int idx, output int lat);
        idx = -1;
        lat = 0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (ack != 3'b000) begin
                lat = c;
                case (ack)
                    3'b001:  idx = 0;
                    3'b010:  idx = 1;
                    3'b100:  idx = 2;
                    default: idx = 3;
                endcase
                break;
            end
        end
        checkOutput("ack_seen", (idx >= 0), 1);
    endtask

    task automatic expectAck(input int expIdx, input int expLat);
        int idx;
        int lat;
        waitAck(idx, lat);
        checkOutput("ack_idx", idx, expIdx);
        if (expLat > 0) checkOutput("ack_latency", lat, expLat);
        checkOutput("grant_at_ack", grant, expIdx);
        checkOutput("locked_at_ack", locked, 1);
    endtask

    // Called on the ack cycle (frame cycle 0); compares every cycle to the ideal frame.
    task automatic checkFrame(input logic [7:0] b, input logic expLockedAfter,
                              input int pulseAt, input logic [2:0] pulseMask);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int t = 0; t < FRAME; t++) begin
            if (t > 0) @(negedge clk);
            checkOutput("frame_line", lineTx, bits[t / BC]);
            checkOutput("frame_busy", busy, 1);
            if (t > 0) checkOutput("frame_no_ack", ack, 0);
            if (t == pulseAt) req = req | pulseMask;
            if (t == pulseAt + 1) req = req & ~pulseMask;
        end
        @(negedge clk);
        checkOutput("post_busy", busy, 0);
        checkOutput("post_line", lineTx, 1);
        checkOutput("post_ack", ack, 0);
        checkOutput("post_locked", locked, expLockedAfter);
    endtask

    task automatic doReset();
        rstN = 1'b0;
        applyStimulus(3'b000, 8'h00, 8'h00, 8'h00, 3'b000);
        repeat (3) @(negedge clk);
        checkOutput("rst_line", lineTx, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ack", ack, 0);
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_locked", locked, 0);
        rstN  = 1'b1;
        rrPtr = 0;
    endtask

    initial begin
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] dv [3];
        logic [2:0] pending;
        int         exp;
        int         n;
        logic       sawAck;
        logic       sawBusy;

        $display("[TB] reset");
        doReset();

        $display("[TB] single byte A5");
        applyStimulus(3'b001, 8'hA5, 8'h00, 8'h00, 3'b001);
        expectAck(pickRr(3'b001, rrPtr), 1);
        applyStimulus(3'b000, 8'h5A, 8'h00, 8'h00, 3'b000);
        checkFrame(8'hA5, 1'b0, -1, 3'b000);
        rrPtr = 1;

        $display("[TB] contention from reset");
        doReset();
        for (int i = 0; i < 3; i++) dv[i] = 8'($urandom);
        pending = 3'b111;
        applyStimulus(pending, dv[0], dv[1], dv[2], 3'b111);
        for (int i = 0; i < 3; i++) begin
            exp = pickRr(pending, rrPtr);
            expectAck(exp, 1);
            pending[exp] = 1'b0;
            req = pending;
            checkFrame(dv[exp], 1'b0, -1, 3'b000);
            rrPtr = (exp + 1) % 3;
        end

        $display("[TB] message lock");
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        dv[0] = 8'($urandom);
        applyStimulus(3'b010, 8'h00, b0, 8'h00, 3'b000);
        expectAck(1, 1);
        applyStimulus(3'b011, dv[0], b1, 8'h00, 3'b001);
        checkFrame(b0, 1'b1, -1, 3'b000);
        expectAck(1, 1);
        applyStimulus(3'b011, dv[0], b2, 8'h00, 3'b011);
        checkFrame(b1, 1'b1, -1, 3'b000);
        expectAck(1, 1);
        applyStimulus(3'b001, dv[0], 8'h00, 8'h00, 3'b001);
        checkFrame(b2, 1'b0, -1, 3'b000);
        rrPtr = 2;
        expectAck(pickRr(3'b001, rrPtr), 1);
        applyStimulus(3'b000, 8'h00, 8'h00, 8'h00, 3'b000);
        checkFrame(dv[0], 1'b0, -1, 3'b000);
        rrPtr = 1;

        $display("[TB] hold timeout");
        dv[2] = 8'($urandom);
        dv[0] = 8'($urandom);
        applyStimulus(3'b100, 8'h00, 8'h00, dv[2], 3'b000);
        expectAck(pickRr(3'b100, rrPtr), 1);
        applyStimulus(3'b001, dv[0], 8'h00, 8'hFF, 3'b001);
        checkFrame(dv[2], 1'b1, -1, 3'b000);
        n = 1;
        for (int c = 0; c < 5 * HOLD_TB; c++) begin
            @(negedge clk);
            if (!locked || (ack != 3'b000)) break;
            n++;
        end
        checkOutput("hold_cycles", n, HOLD_TB);
        checkOutput("hold_no_early_ack", ack, 0);
        rrPtr = 0;
        expectAck(pickRr(3'b001, rrPtr), 1);
        applyStimulus(3'b000, 8'h00, 8'h00, 8'h00, 3'b000);
        checkFrame(dv[0], 1'b0, -1, 3'b000);
        rrPtr = 1;

        $display("[TB] reset mid-frame");
        applyStimulus(3'b001, 8'($urandom), 8'h00, 8'h00, 3'b001);
        expectAck(pickRr(3'b001, rrPtr), 1);
        req = 3'b000;
        repeat (4 * BC + 3) @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("midrst_line", lineTx, 1);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_locked", locked, 0);
        checkOutput("midrst_ack", ack, 0);
        repeat (2) @(negedge clk);
        rstN  = 1'b1;
        rrPtr = 0;
        dv[0] = 8'($urandom);
        applyStimulus(3'b001, dv[0], 8'h00, 8'h00, 3'b001);
        expectAck(0, 1);
        req = 3'b000;
        checkFrame(dv[0], 1'b0, -1, 3'b000);
        rrPtr = 1;

        $display("[TB] withdraw during busy");
        dv[2] = 8'($urandom);
        applyStimulus(3'b100, 8'h00, 8'h33, dv[2], 3'b111);
        expectAck(pickRr(3'b100, rrPtr), 1);
        req = 3'b000;
        checkFrame(dv[2], 1'b0, 20, 3'b010);
        rrPtr   = 0;
        sawAck  = 1'b0;
        sawBusy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack != 3'b000) sawAck = 1'b1;
            if (busy) sawBusy = 1'b1;
        end
        checkOutput("withdraw_no_ack", sawAck, 0);
        checkOutput("withdraw_no_frame", sawBusy, 0);

        $display("[TB] random round-robin rounds");
        for (int round = 0; round < 5; round++) begin
            for (int i = 0; i < 3; i++) dv[i] = 8'($urandom);
            pending = 3'($urandom_range(1, 7));
            applyStimulus(pending, dv[0], dv[1], dv[2], 3'b111);
            for (int k = 0; k < 3; k++) begin
                if (pending == 3'b000) break;
                exp = pickRr(pending, rrPtr);
                expectAck(exp, 1);
                pending[exp] = 1'b0;
                req = pending;
                checkFrame(dv[exp], 1'b0, -1, 3'b000);
                rrPtr = (exp + 1) % 3;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
